// File: rtl/router_pkt_ctrl.sv
// Packet-reception controller for the 1x3 router: walks one packet (header, payload, parity)
// into the addressed FIFO, stalling on busy/full FIFOs and aborting on that FIFO's soft reset.
module router_pkt_ctrl (
  input  logic       router_clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] sel_idx;
  logic       sel_empty, sel_soft;
  logic [7:0] out_q;

  // Output vector order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy.
  function automatic logic [7:0] decode_out(input state_e s);
    case (s)
      DECODE_ADDRESS:     decode_out = 8'b1000_0000;
      LOAD_FIRST_DATA:    decode_out = 8'b0100_0001;
      LOAD_DATA:          decode_out = 8'b0010_0100;
      FIFO_FULL_STATE:    decode_out = 8'b0000_1001;
      LOAD_AFTER_FULL:    decode_out = 8'b0001_0101;
      LOAD_PARITY:        decode_out = 8'b0000_0101;
      CHECK_PARITY_ERROR: decode_out = 8'b0000_0011;
      WAIT_TILL_EMPTY:    decode_out = 8'b0000_0001;
      default:            decode_out = 8'b1000_0000;
    endcase
  endfunction

  always_comb begin
    sel_idx   = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
    sel_empty = 1'b0;
    sel_soft  = 1'b0;
    case (sel_idx)
      2'd0:    begin sel_empty = fifo_empty_0; sel_soft = soft_reset_0; end
      2'd1:    begin sel_empty = fifo_empty_1; sel_soft = soft_reset_1; end
      2'd2:    begin sel_empty = fifo_empty_2; sel_soft = soft_reset_2; end
      default: begin sel_empty = 1'b0;         sel_soft = 1'b0;         end
    endcase

    addr_d  = addr_q;
    state_d = state_q;
    if (state_q == DECODE_ADDRESS && pkt_valid) addr_d = data_in;

    if (state_q != DECODE_ADDRESS && sel_soft) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != 2'd3)
            state_d = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:    state_d = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (sel_empty) state_d = LOAD_FIRST_DATA;
        default:            state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered alongside the state so they always equal the decode of state_q.
  always_ff @(posedge router_clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'b00;
      out_q   <= decode_out(DECODE_ADDRESS);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= decode_out(state_d);
    end
  end

  assign {detect_add, lfd_state, ld_state, laf_state,
          full_state, write_enb_reg, rst_int_reg, busy} = out_q;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Scoreboard bench for router_pkt_ctrl: a reference model predicts the outputs after each
// edge, a monitor compares them against the DUT one cycle at a time.
module tb_router_pkt_ctrl;

  logic       router_clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  router_pkt_ctrl dut (
    .router_clock (router_clock),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty_0 (fifo_empty_0),
    .fifo_empty_1 (fifo_empty_1),
    .fifo_empty_2 (fifo_empty_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy)
  );

  always #5 router_clock = ~router_clock;

  // Model phases, named after what the controller is doing with the packet.
  localparam int IDLE = 0, HDR = 1, PAYLOAD = 2, STALL = 3, RESUME = 4,
                 PARITY = 5, CHECK = 6, WAITQ = 7;

  int         m_phase = IDLE;
  int         m_addr  = 0;
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc_no   = 0;

  function automatic logic [7:0] expect_outs(input int p);
    logic det, lfd, ld, laf, ful, we, ri, bsy;
    det = (p == IDLE);
    lfd = (p == HDR);
    ld  = (p == PAYLOAD);
    laf = (p == RESUME);
    ful = (p == STALL);
    we  = (p == PAYLOAD) || (p == PARITY) || (p == RESUME);
    ri  = (p == CHECK);
    bsy = !((p == IDLE) || (p == PAYLOAD));
    return {det, lfd, ld, laf, ful, we, ri, bsy};
  endfunction

  // Apply one cycle of inputs, advance the model across the coming edge, queue the prediction.
  task automatic cyc(input bit pv, input bit [1:0] din, input bit full, input bit [2:0] emp,
                     input bit [2:0] sr, input bit pd, input bit lpv, input bit rst);
    int idx;
    int nxt;
    pkt_valid = pv;  data_in = din;  fifo_full = full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    parity_done = pd;  low_pkt_valid = lpv;  reset = rst;

    idx = (m_phase == IDLE) ? int'(din) : m_addr;
    nxt = m_phase;
    if (rst) begin
      nxt = IDLE;
    end else if (m_phase != IDLE && idx < 3 && sr[idx]) begin
      nxt = IDLE;
    end else begin
      case (m_phase)
        IDLE:    if (pv && din != 2'd3) nxt = emp[din] ? HDR : WAITQ;
        HDR:     nxt = PAYLOAD;
        PAYLOAD: nxt = full ? STALL : (!pv ? PARITY : PAYLOAD);
        STALL:   nxt = full ? STALL : RESUME;
        RESUME:  nxt = pd ? IDLE : (lpv ? PARITY : PAYLOAD);
        PARITY:  nxt = CHECK;
        CHECK:   nxt = full ? STALL : IDLE;
        WAITQ:   nxt = (idx < 3 && emp[idx]) ? HDR : WAITQ;
        default: nxt = IDLE;
      endcase
    end
    if (rst) m_addr = 0;
    else if (m_phase == IDLE && pv) m_addr = int'(din);
    m_phase = nxt;
    exp_q.push_back(expect_outs(m_phase));
    @(negedge router_clock);
  endtask

  initial begin : monitor
    logic [7:0] act, exp;
    forever begin
      @(posedge router_clock);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {detect_add, lfd_state, ld_state, laf_state,
               full_state, write_enb_reg, rst_int_reg, busy};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL outs cycle %0d: got %b expected %b (det,lfd,ld,laf,full,we,rst_int,busy)",
                      cyc_no, act, exp);
      end
    end
  end

  initial begin : stim
    // Reset, 2 cycles
    cyc(0, 0, 0, 3'b111, 3'b000, 0, 0, 1);
    cyc(0, 0, 0, 3'b111, 3'b000, 0, 0, 1);
    // Normal packet to FIFO 1, four payload cycles
    cyc(1, 1, 0, 3'b111, 3'b000, 0, 0, 0);
    repeat (5) cyc(1, 1, 0, 3'b111, 3'b000, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 3'b111, 3'b000, 0, 0, 0);
    // FIFO 2 busy for 5 cycles, then empties
    repeat (5) cyc(1, 2, 0, 3'b011, 3'b000, 0, 0, 0);
    cyc(1, 2, 0, 3'b111, 3'b000, 0, 0, 0);
    repeat (2) cyc(1, 2, 0, 3'b111, 3'b000, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 3'b111, 3'b000, 0, 0, 0);
    // Full stall, resume into payload, then into parity, then straight to decode
    for (int k = 0; k < 3; k++) begin
      repeat (3) cyc(1, 0, 0, 3'b111, 3'b000, 0, 0, 0);
      repeat (3) cyc(1, 0, 1, 3'b111, 3'b000, 0, 0, 0);
      cyc(1, 0, 0, 3'b111, 3'b000, 0, 0, 0);
      cyc(1, 0, 0, 3'b111, 3'b000, (k == 2), (k == 1), 0);
      repeat (4) cyc(0, 0, 0, 3'b111, 3'b000, 0, 0, 0);
    end
    // Invalid address 3 is ignored
    repeat (4) cyc(1, 3, 0, 3'b111, 3'b000, 0, 0, 0);
    cyc(0, 0, 0, 3'b111, 3'b000, 0, 0, 0);
    // Soft-reset abort: only the addressed FIFO's soft reset matters
    repeat (3) cyc(1, 0, 0, 3'b111, 3'b000, 0, 0, 0);
    cyc(1, 0, 0, 3'b111, 3'b100, 0, 0, 0);
    cyc(1, 0, 0, 3'b111, 3'b010, 0, 0, 0);
    cyc(1, 0, 0, 3'b111, 3'b001, 0, 0, 0);
    cyc(0, 0, 0, 3'b111, 3'b000, 0, 0, 0);
    // Reset taken while stalled on a full FIFO
    repeat (3) cyc(1, 2, 0, 3'b111, 3'b000, 0, 0, 0);
    repeat (2) cyc(1, 2, 1, 3'b111, 3'b000, 0, 0, 0);
    cyc(1, 2, 1, 3'b111, 3'b000, 0, 0, 1);
    // addr_q must be back at 0: FIFO 0 busy, FIFO 2 free while waiting
    cyc(1, 0, 0, 3'b110, 3'b000, 0, 0, 0);
    cyc(0, 0, 0, 3'b110, 3'b100, 0, 0, 0);
    cyc(0, 0, 0, 3'b111, 3'b001, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
          3'($urandom_range(0, 7)),
          {$urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0},
          $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
    end
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge router_clock);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
